// File: rtl/hcsr04_presence_pkg.sv
// Shared types and cycle-count helpers for the HC-SR04 presence detector.
// All timing parameters are given in physical units; these helpers turn
// them into clock-cycle counts so the RTL never needs a divider at runtime.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int unsigned HZ_PER_MHZ      = 32'd1_000_000;
    localparam int unsigned HZ_PER_KHZ      = 32'd1_000;
    // Round-trip sound travel time for one centimetre of distance.
    localparam int unsigned SOUND_US_PER_CM = 32'd58;
    localparam int unsigned DIST_W          = 32'd9;

    function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
        return clk_hz / HZ_PER_MHZ;
    endfunction

    function automatic int unsigned trig_cyc(input int unsigned clk_hz,
                                             input int unsigned trig_us);
        return cyc_per_us(clk_hz) * trig_us;
    endfunction

    function automatic int unsigned cm_cyc(input int unsigned clk_hz);
        return cyc_per_us(clk_hz) * SOUND_US_PER_CM;
    endfunction

    function automatic int unsigned period_cyc(input int unsigned clk_hz,
                                               input int unsigned period_ms);
        return (clk_hz / HZ_PER_KHZ) * period_ms;
    endfunction

    function automatic int unsigned timeout_cyc(input int unsigned clk_hz,
                                                input int unsigned timeout_us);
        return cyc_per_us(clk_hz) * timeout_us;
    endfunction

endpackage

// File: rtl/hcsr04_presence_if.sv
// Sensor-side and result-side signals of the presence detector.
// The detector is the slave; whoever drives the echo line and consumes
// the results (sensor model / LCD driver) is the master.
interface hcsr04_presence_if;
    logic       echo;
    logic       trig;
    logic [8:0] dist_cm;
    logic       valid;
    logic       timeout;
    logic       distancia;

    modport master (
        output echo,
        input  trig,
        input  dist_cm,
        input  valid,
        input  timeout,
        input  distancia
    );

    modport slave (
        input  echo,
        output trig,
        output dist_cm,
        output valid,
        output timeout,
        output distancia
    );
endinterface

// File: rtl/hcsr04_presence_sync_2ff.sv
// One-bit two-flop synchronizer for bringing the asynchronous echo line
// into the clk domain. Both flops clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/hcsr04_presence.sv
// HC-SR04 presence detector: periodic trigger, echo timing, cycle-to-cm
// conversion by prescaled counting, and a debounced near/far flag.
// distancia = 1 means nobody near (LCD off), 0 means object near.
module hcsr04_presence
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 32'd50_000_000,
    parameter int unsigned TRIG_US    = 32'd10,
    parameter int unsigned PERIOD_MS  = 32'd60,
    parameter int unsigned TIMEOUT_US = 32'd30000,
    parameter int unsigned THRESH_CM  = 32'd50,
    parameter int unsigned MAX_CM     = 32'd400,
    parameter int unsigned NEAR_CNT   = 32'd3
) (
    input  logic               clk,
    input  logic               reset,
    hcsr04_presence_if.slave   bus
);

    localparam int unsigned TRIG_CYC_L    = trig_cyc(CLK_HZ, TRIG_US);
    localparam int unsigned CM_CYC_L      = cm_cyc(CLK_HZ);
    localparam int unsigned PERIOD_CYC_L  = period_cyc(CLK_HZ, PERIOD_MS);
    localparam int unsigned TIMEOUT_CYC_L = timeout_cyc(CLK_HZ, TIMEOUT_US);

    localparam int unsigned PER_W  = $clog2(PERIOD_CYC_L + 32'd1);
    localparam int unsigned TRIG_W = $clog2(TRIG_CYC_L + 32'd1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC_L + 32'd1);
    localparam int unsigned CM_W   = $clog2(CM_CYC_L + 32'd1);
    localparam int unsigned DB_W   = $clog2(NEAR_CNT + 32'd1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC_L - 32'd1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYC_L - 32'd1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC_L - 32'd1);
    localparam logic [CM_W-1:0]   CM_LAST   = CM_W'(CM_CYC_L - 32'd1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(NEAR_CNT - 32'd1);
    localparam logic [DIST_W-1:0] DIST_MAX  = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0] DIST_THR  = DIST_W'(THRESH_CM);

    // Echo synchronization and edge detection
    logic w_echo_s;
    logic r_echo_d;
    logic w_echo_rise;
    logic w_echo_fall;

    // Period timer
    logic [PER_W-1:0] r_period_cnt;
    logic             w_period_wrap;

    // FSM and measurement state
    state_t            r_state;
    logic              r_trig;
    logic [TRIG_W-1:0] r_trig_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CM_W-1:0]   r_pre_cnt;
    logic [DIST_W-1:0] r_cm_cnt;
    logic [DIST_W-1:0] r_dist_cm;
    logic              r_valid;
    logic              r_timeout;
    logic              r_distancia;
    logic [DB_W-1:0]   r_db_cnt;

    logic              w_to_hit;
    logic              w_meas_near;
    logic              w_class_differs;

    sync_2ff u_sync_echo (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.echo),
        .o_q   (w_echo_s)
    );

    // Previous synchronized echo level, used for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_echo_d <= 1'b0;
        end else begin
            r_echo_d <= w_echo_s;
        end
    end

    assign w_echo_rise = w_echo_s & ~r_echo_d;
    assign w_echo_fall = ~w_echo_s & r_echo_d;

    // Free-running measurement period counter, independent of FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt == PER_LAST) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(32'd1);
        end
    end

    assign w_period_wrap = (r_period_cnt == PER_LAST);

    // The timeout budget is measured from trigger fall and shared by the
    // wait-for-echo and measure phases.
    assign w_to_hit = (r_to_cnt >= TO_LAST);

    // Timeouts always count as far; otherwise near is strictly below threshold.
    assign w_meas_near     = ~r_timeout & (r_dist_cm < DIST_THR);
    // distancia=1 means far, so a near result disagrees when distancia is 1.
    assign w_class_differs = (w_meas_near == r_distancia);

    // Measurement sequencer with registered outputs and debounce update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_trig_cnt  <= '0;
            r_to_cnt    <= '0;
            r_pre_cnt   <= '0;
            r_cm_cnt    <= '0;
            r_dist_cm   <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_distancia <= 1'b1;
            r_db_cnt    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_trig <= 1'b0;
                    if (w_period_wrap) begin
                        r_state    <= ST_TRIG;
                        r_trig     <= 1'b1;
                        r_trig_cnt <= '0;
                    end
                end

                ST_TRIG: begin
                    // Echo edges seen here are deliberately ignored.
                    if (r_trig_cnt == TRIG_LAST) begin
                        r_trig   <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= ST_WAIT_ECHO;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + TRIG_W'(32'd1);
                    end
                end

                ST_WAIT_ECHO: begin
                    if (w_echo_rise) begin
                        // The rise cycle is the first echo-high cycle.
                        r_pre_cnt <= CM_W'(32'd1);
                        r_cm_cnt  <= '0;
                        r_to_cnt  <= r_to_cnt + TO_W'(32'd1);
                        r_state   <= ST_MEASURE;
                    end else if (w_to_hit) begin
                        r_dist_cm <= DIST_MAX;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(32'd1);
                    end
                end

                ST_MEASURE: begin
                    if (w_echo_fall) begin
                        r_dist_cm <= r_cm_cnt;
                        r_timeout <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (w_to_hit) begin
                        r_dist_cm <= DIST_MAX;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(32'd1);
                        if (r_pre_cnt == CM_LAST) begin
                            r_pre_cnt <= '0;
                            if (r_cm_cnt >= DIST_MAX) begin
                                r_cm_cnt <= DIST_MAX;
                            end else begin
                                r_cm_cnt <= r_cm_cnt + DIST_W'(32'd1);
                            end
                        end else begin
                            r_pre_cnt <= r_pre_cnt + CM_W'(32'd1);
                        end
                    end
                end

                ST_DONE: begin
                    if (w_class_differs) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_distancia <= ~r_distancia;
                            r_db_cnt    <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(32'd1);
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_trig  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trig      = r_trig;
    assign bus.dist_cm   = r_dist_cm;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.distancia = r_distancia;

endmodule

// File: tb/tb_hcsr04_presence.sv
// Directed bench for hcsr04_presence using a scaled clock
// (1 MHz, 2 ms period, 1.5 ms timeout, 10 cm threshold, 24 cm max).
module tb_hcsr04_presence;

    localparam int unsigned P_CYC  = 2000;
    localparam int unsigned T_CYC  = 10;
    localparam int unsigned TO_CYC = 1500;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    hcsr04_presence_if u_if ();

    hcsr04_presence #(
        .CLK_HZ     (32'd1_000_000),
        .TRIG_US    (32'd10),
        .PERIOD_MS  (32'd2),
        .TIMEOUT_US (32'd1500),
        .THRESH_CM  (32'd10),
        .MAX_CM     (32'd24),
        .NEAR_CNT   (32'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_trig(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P_CYC + 100; i++) begin
            @(negedge clk);
            if (u_if.trig === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P_CYC + 100; i++) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full measurement: echo of 'width' cycles starting 'dly' cycles
    // after trigger fall (width 0 = no echo).
    task automatic measure(input int dly, input int width,
                           output logic [8:0] d, output logic to,
                           output logic v_after, output logic dist_after,
                           output int fall_c, output int efall_c,
                           output int valid_c, output bit ok);
        bit ok1, ok2, ok3;
        wait_trig(1'b1, ok1);
        wait_trig(1'b0, ok2);
        fall_c = cyc;
        if (width > 0) begin
            repeat (dly) @(negedge clk);
            u_if.echo = 1'b1;
            repeat (width) @(negedge clk);
            u_if.echo = 1'b0;
        end
        efall_c = cyc;
        wait_valid(ok3);
        valid_c = cyc;
        d       = u_if.dist_cm;
        to      = u_if.timeout;
        @(negedge clk);
        v_after    = u_if.valid;
        dist_after = u_if.distancia;
        ok = ok1 & ok2 & ok3;
    endtask

    task automatic test_reset();
        bit ok;
        int rel, rise_c, fall_c;
        logic [8:0] d;
        logic to;
        reset     = 1'b0;
        u_if.echo = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (u_if.trig !== 1'b0)      begin bad++; $display("FAIL rst_trig: got %b want 0", u_if.trig); end
        total++; if (u_if.valid !== 1'b0)     begin bad++; $display("FAIL rst_valid: got %b want 0", u_if.valid); end
        total++; if (u_if.timeout !== 1'b0)   begin bad++; $display("FAIL rst_timeout: got %b want 0", u_if.timeout); end
        total++; if (u_if.dist_cm !== 9'd0)   begin bad++; $display("FAIL rst_dist: got %0d want 0", u_if.dist_cm); end
        total++; if (u_if.distancia !== 1'b1) begin bad++; $display("FAIL rst_distancia: got %b want 1", u_if.distancia); end
        reset = 1'b1;
        rel   = cyc;
        wait_trig(1'b1, ok);
        rise_c = cyc;
        total++; if (!ok || (rise_c - rel) != P_CYC) begin bad++; $display("FAIL first_trig: got %0d want %0d", rise_c - rel, P_CYC); end
        wait_trig(1'b0, ok);
        fall_c = cyc;
        total++; if (!ok || (fall_c - rise_c) != T_CYC) begin bad++; $display("FAIL trig_width: got %0d want %0d", fall_c - rise_c, T_CYC); end
        wait_valid(ok);
        d  = u_if.dist_cm;
        to = u_if.timeout;
        total++; if (!ok || (cyc - fall_c) != TO_CYC) begin bad++; $display("FAIL noecho_lat: got %0d want %0d", cyc - fall_c, TO_CYC); end
        total++; if (to !== 1'b1)   begin bad++; $display("FAIL noecho_to: got %b want 1", to); end
        total++; if (d !== 9'd24)   begin bad++; $display("FAIL noecho_dist: got %0d want 24", d); end
        @(negedge clk);
        total++; if (u_if.valid !== 1'b0)     begin bad++; $display("FAIL noecho_pulse: got %b want 0", u_if.valid); end
        total++; if (u_if.distancia !== 1'b1) begin bad++; $display("FAIL noecho_distancia: got %b want 1", u_if.distancia); end
    endtask

    task automatic test_measure_basic();
        logic [8:0] d; logic to, va, da; int fc, ec, vc; bit ok;
        // 319 cycles -> floor(319/58) = 5 cm
        measure(100, 319, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok)          begin bad++; $display("FAIL basic_wait: got timeout want valid"); end
        total++; if (d !== 9'd5)   begin bad++; $display("FAIL basic_dist: got %0d want 5", d); end
        total++; if (to !== 1'b0)  begin bad++; $display("FAIL basic_to: got %b want 0", to); end
        total++; if ((vc - ec) != 3) begin bad++; $display("FAIL basic_lat: got %0d want 3", vc - ec); end
        total++; if (va !== 1'b0)  begin bad++; $display("FAIL basic_pulse: got %b want 0", va); end
        total++; if (da !== 1'b1)  begin bad++; $display("FAIL basic_distancia: got %b want 1", da); end
    endtask

    task automatic test_debounce_near();
        logic [8:0] d; logic to, va, da; int fc, ec, vc; bit ok;
        // far at exactly the threshold (580 cycles = 10 cm) breaks the run
        measure(100, 580, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok || d !== 9'd10) begin bad++; $display("FAIL thr_dist: got %0d want 10", d); end
        total++; if (da !== 1'b1)        begin bad++; $display("FAIL thr_distancia: got %b want 1", da); end
        for (int k = 1; k <= 3; k++) begin
            measure(100, 319, d, to, va, da, fc, ec, vc, ok);
            total++;
            if (!ok || da !== ((k == 3) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL near_run%0d: got %b want %b", k, da, (k == 3) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_timeout_hold();
        logic [8:0] d; logic to, va, da; int fc, ec, vc; bit ok;
        for (int k = 0; k < 2; k++) begin
            measure(0, 0, d, to, va, da, fc, ec, vc, ok);
            total++; if (!ok || to !== 1'b1 || (vc - fc) != TO_CYC) begin bad++; $display("FAIL hold_to%0d: got to=%b lat=%0d want to=1 lat=%0d", k, to, vc - fc, TO_CYC); end
            total++; if (da !== 1'b0) begin bad++; $display("FAIL hold_distancia%0d: got %b want 0", k, da); end
        end
        // 579 cycles -> 9 cm, just inside threshold
        measure(100, 579, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok || d !== 9'd9) begin bad++; $display("FAIL hold_near_dist: got %0d want 9", d); end
        total++; if (da !== 1'b0)       begin bad++; $display("FAIL hold_near_distancia: got %b want 0", da); end
    endtask

    task automatic test_release_far();
        logic [8:0] d; logic to, va, da; int fc, ec, vc; bit ok;
        measure(100, 880, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok || d !== 9'd15) begin bad++; $display("FAIL far1_dist: got %0d want 15", d); end
        total++; if (da !== 1'b0)        begin bad++; $display("FAIL far1_distancia: got %b want 0", da); end
        // 1450 cycles -> 25 cm, saturated to 24 without timing out
        measure(20, 1450, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok || d !== 9'd24 || to !== 1'b0) begin bad++; $display("FAIL sat: got dist=%0d to=%b want dist=24 to=0", d, to); end
        total++; if (da !== 1'b0)        begin bad++; $display("FAIL far2_distancia: got %b want 0", da); end
        measure(100, 580, d, to, va, da, fc, ec, vc, ok);
        total++; if (!ok || da !== 1'b1) begin bad++; $display("FAIL far3_distancia: got %b want 1", da); end
    endtask

    task automatic test_stuck_high();
        bit ok, seen;
        int rise_c, fall_c, vc, rise2;
        logic [8:0] d; logic to;
        seen = 1'b0; vc = 0; d = 9'd0; to = 1'b0;
        wait_trig(1'b1, ok);
        rise_c = cyc;
        wait_trig(1'b0, ok);
        fall_c = cyc;
        repeat (100) @(negedge clk);
        u_if.echo = 1'b1;
        for (int i = 0; i < 1800; i++) begin
            @(negedge clk);
            if (!seen && u_if.valid === 1'b1) begin
                seen = 1'b1; vc = cyc; d = u_if.dist_cm; to = u_if.timeout;
            end
        end
        u_if.echo = 1'b0;
        total++; if (!seen || (vc - fall_c) != TO_CYC) begin bad++; $display("FAIL stuck_lat: got %0d want %0d", vc - fall_c, TO_CYC); end
        total++; if (to !== 1'b1 || d !== 9'd24) begin bad++; $display("FAIL stuck_val: got to=%b dist=%0d want to=1 dist=24", to, d); end
        wait_trig(1'b1, ok);
        rise2 = cyc;
        total++; if (!ok || (rise2 - rise_c) != P_CYC) begin bad++; $display("FAIL stuck_period: got %0d want %0d", rise2 - rise_c, P_CYC); end
    endtask

    task automatic test_echo_during_trig();
        bit ok;
        int fall_c;
        wait_trig(1'b1, ok);
        repeat (3) @(negedge clk);
        u_if.echo = 1'b1;
        wait_trig(1'b0, ok);
        fall_c = cyc;
        repeat (50) @(negedge clk);
        u_if.echo = 1'b0;
        wait_valid(ok);
        total++; if (!ok || (cyc - fall_c) != TO_CYC) begin bad++; $display("FAIL trigecho_lat: got %0d want %0d", cyc - fall_c, TO_CYC); end
        total++; if (u_if.timeout !== 1'b1) begin bad++; $display("FAIL trigecho_to: got %b want 1", u_if.timeout); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] d; logic to, va, da; int fc, ec, vc; bit ok, seen;
        int rel, nv;
        for (int k = 0; k < 3; k++) measure(100, 319, d, to, va, da, fc, ec, vc, ok);
        total++; if (da !== 1'b0) begin bad++; $display("FAIL pre_rst_distancia: got %b want 0", da); end
        wait_trig(1'b1, ok);
        wait_trig(1'b0, ok);
        repeat (100) @(negedge clk);
        u_if.echo = 1'b1;
        repeat (150) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (u_if.trig !== 1'b0 || u_if.valid !== 1'b0) begin bad++; $display("FAIL midrst_out: got trig=%b valid=%b want 0 0", u_if.trig, u_if.valid); end
        total++; if (u_if.distancia !== 1'b1) begin bad++; $display("FAIL midrst_distancia: got %b want 1", u_if.distancia); end
        total++; if (u_if.dist_cm !== 9'd0)   begin bad++; $display("FAIL midrst_dist: got %0d want 0", u_if.dist_cm); end
        repeat (3) @(negedge clk);
        u_if.echo = 1'b0;
        reset     = 1'b1;
        rel       = cyc;
        nv = 0; seen = 1'b0;
        for (int i = 0; i < P_CYC + 100; i++) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) nv++;
            if (u_if.trig === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (!seen || (cyc - rel) != P_CYC) begin bad++; $display("FAIL midrst_trig: got %0d want %0d", cyc - rel, P_CYC); end
        total++; if (nv != 0) begin bad++; $display("FAIL midrst_novalid: got %0d want 0", nv); end
    endtask

    initial begin
        u_if.echo = 1'b0;
        test_reset();
        test_measure_basic();
        test_debounce_near();
        test_timeout_hold();
        test_release_far();
        test_stuck_high();
        test_echo_during_trig();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hcsr04_presence.md
# hcsr04_presence

Ultrasonic presence detector that drives an HC-SR04 sensor and produces the `distancia` flag consumed by the LCD message driver. It fires periodic trigger pulses, times the echo, converts the echo width to centimetres without a divider, and debounces the near/far decision across consecutive measurements. `distancia` high means nobody is near, which keeps the LCD off. `distancia` low means an object is inside the threshold, which wakes the LCD.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TRIG_US`, 10: trigger pulse width.
- `PERIOD_MS`, 60: measurement repetition period, counted from trigger rise to trigger rise.
- `TIMEOUT_US`, 30000: maximum time from trigger fall to measurement end. Must satisfy TRIG_US + TIMEOUT_US < PERIOD_MS·1000.
- `THRESH_CM`, 50: near threshold. Near means `dist_cm` < THRESH_CM.
- `MAX_CM`, 400: saturation and no-echo distance value.
- `NEAR_CNT`, 3: number of consecutive agreeing measurements required to change `distancia`.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `echo`, in, 1: sensor echo. Asynchronous to `clk`.
- `trig`, out, 1: sensor trigger.
- `dist_cm`, out, 9: last measured distance, saturated at MAX_CM.
- `valid`, out, 1: one-cycle pulse when `dist_cm` updates.
- `timeout`, out, 1: registered with `valid`. Set to 1 if the last measurement timed out.
- `distancia`, out, 1: debounced presence flag. 1 = far or empty, 0 = near.

## Operation
Echo synchronization:
- `echo` passes through a 2-FF synchronizer. All logic uses the synchronized signal `echo_s`.

State machine and transitions:
- IDLE → TRIG when the period counter wraps.
- TRIG: hold `trig`=1 for TRIG_CYC = CLK_HZ/1e6·TRIG_US cycles, then go to WAIT_ECHO. The timeout counter clears on this transition.
- WAIT_ECHO → MEASURE on the `echo_s` rising edge. WAIT_ECHO → DONE with timeout=1 and dist=MAX_CM if the timeout counter reaches TIMEOUT_CYC.
- MEASURE: the cm prescaler counts CM_CYC = CLK_HZ/1e6·58 cycles. At each prescaler wrap the cm counter increments, saturating at MAX_CM.
- MEASURE → DONE on the `echo_s` falling edge with timeout=0. MEASURE → DONE with timeout=1 and dist=MAX_CM on timeout (echo stuck high).
- DONE: register `dist_cm` and `timeout`, pulse `valid`, update the debounce counter, return to IDLE.

Period counter:
- Free-running modulo PERIOD_CYC = CLK_HZ/1000·PERIOD_MS, independent of FSM state.
- The wrap is ignored in any state other than IDLE. The parameter constraint prevents this from happening.

Debounce:
- A measurement is classified near when dist < THRESH_CM. Timeout measurements are always far.
- If the class differs from the current `distancia` state, the agreement counter increments. Otherwise it clears.
- When the counter reaches NEAR_CNT, `distancia` toggles and the counter clears.

Arithmetic:
- dist_cm = floor(echo_high_cycles / CM_CYC), saturated at MAX_CM.
- The cm counter is 9 bits and never wraps.

## Timing
Reset values (reset=0 at a clk edge):
- `trig`=0, `valid`=0, `timeout`=0, `dist_cm`=0, `distancia`=1.
- FSM=IDLE, all counters=0, synchronizer flops=0.

Trigger timing:
- The first trigger rises PERIOD_CYC cycles after reset release.
- Subsequent triggers rise exactly every PERIOD_CYC cycles.
- `trig` high width is exactly TRIG_CYC cycles.

Latencies:
- `echo_s` lags `echo` by 2 cycles. Edge detection adds 1 more cycle.
- `valid` asserts 1 cycle after the echo falling edge is detected, or on the timeout cycle.
- `distancia` changes in the cycle after the `valid` that completes NEAR_CNT agreement.

Boundary conditions:
- Reset mid-measurement: `trig` drops the next cycle and no `valid` is issued.
- Echo already high in WAIT_ECHO, with no rising edge: treated as no echo until an edge occurs, which ends in a timeout.
- Echo rising edge during TRIG: ignored.

## Structure
- Package `hcsr04_pkg`: state enum (IDLE, TRIG, WAIT_ECHO, MEASURE, DONE) and functions deriving TRIG_CYC, CM_CYC, PERIOD_CYC and TIMEOUT_CYC from parameters.
- One sub-module: `sync_2ff`, a 1-bit two-flop synchronizer with reset value 0.

## Test plan
Directed scenarios, run with the default parameters:
- Reset release with no echo: `trig` rises at cycle 3_000_000 and stays high 500 cycles. `valid` arrives with timeout=1, dist_cm=400 and `distancia`=1.
- Echo high for 1160 µs (58000 cycles), starting 100 µs after `trig` falls: dist_cm=20, timeout=0, `valid` is a single cycle.
- Three consecutive 20 cm echoes: `distancia` stays 1 after the 1st and 2nd `valid` and goes 0 after the 3rd. A near, far, near, near, near sequence takes 3 nears after the far to flip.
- With `distancia`=0, three 100 cm echoes flip it back to 1. Two timeouts followed by one near leave it at 0.
- Echo stuck high for 40 ms: timeout=1 and dist_cm=400 at 30 ms after `trig` falls. The next `trig` is still on the period schedule.
- Reset asserted halfway through a 20 cm echo: `trig`=0, no `valid`, `distancia`=1. After release, the first trigger follows after PERIOD_CYC cycles.
